// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and the BCD-to-segment decode function for the
// four-digit seven-segment scanner. Segment vectors are active-low and
// ordered a..g in bits [6:0].
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Non-decimal nibbles show a dash so bad upstream data is visible.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to active-low a..g segment decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);

    // Pure table lookup; the scan top muxes the digit in front of this.
    always_comb begin
        seg_n = bcd_to_seg(nib);
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit time-multiplexed seven-segment driver.
// Inputs are latched once per frame (end of digit 3's slot), each digit slot
// is SCAN_DIV cycles, and brightness is a PWM window of (bright+1)/8 of the
// slot. seg/an are registered together, one cycle behind the (idx,cnt) state.
// Optional: define SEG7_BLANK_EN for leading-zero blanking of digits 3..1.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [2:0]  bright,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int            CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam int            SLOT8   = SCAN_DIV / 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   dig_q, dig_d;
    logic [3:0]    dp_q, dp_d;
    logic [2:0]    br_q, br_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q, tick_d;

    logic          wrap;
    logic          frame_end;
    logic          lit;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;
    logic [6:0]    body;

    seg7_decode u_decode (
        .nib   (cur_nib),
        .seg_n (dec_seg)
    );

    // Scan counters, frame latch, PWM window and registered output build.
    always_comb begin
        wrap      = (cnt_q == CNT_MAX);
        frame_end = wrap && (idx_q == 2'd3);

        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        idx_d = wrap ? idx_q + 2'd1 : idx_q;

        // Inputs only enter at the frame boundary so a frame never tears.
        dig_d = frame_end ? digits_in : dig_q;
        dp_d  = frame_end ? dp_in     : dp_q;
        br_d  = frame_end ? bright    : br_q;

        cur_nib = dig_q[{idx_q, 2'b00} +: 4];
        lit     = 32'(cnt_q) < ((32'(br_q) + 32'd1) * 32'(SLOT8));

`ifdef SEG7_BLANK_EN
        // A digit is blank while it and everything to its left is zero.
        begin
            logic [3:0] blank;
            blank[3] = (dig_q[15:12] == 4'd0);
            blank[2] = blank[3] && (dig_q[11:8] == 4'd0);
            blank[1] = blank[2] && (dig_q[7:4]  == 4'd0);
            blank[0] = 1'b0;
            body = blank[idx_q] ? SEG_BLANK : dec_seg;
        end
`else
        body = dec_seg;
`endif

        seg_d  = lit ? {~dp_q[idx_q], body} : SEG_OFF;
        an_d   = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        tick_d = frame_end;
    end

    // All state, including the outputs, updates on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            dig_q  <= 16'h0000;
            dp_q   <= 4'h0;
            br_q   <= 3'd0;
            seg_q  <= SEG_OFF;
            an_q   <= AN_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dig_q  <= dig_d;
            dp_q   <= dp_d;
            br_q   <= br_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed scoreboard bench for seg7_scan with SCAN_DIV=8.
// A frame-position model predicts each cycle's seg/an/frame_tick; predictions
// are queued before the edge and compared after it.
module tb_seg7_scan;

    localparam int SD = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [2:0]  bright;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    seg7_scan #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .bright     (bright),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic       ft;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] tbl [16];

    // model state
    int          m_pos;
    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic [2:0]  m_br;

    int passes = 0;
    int total  = 0;
    int ft_cnt, lit_cnt;
    bit seen_dash;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t       e;
        exp_t       got;
        int         d, c;
        logic [3:0] nib;
        logic       blank;
        if (rst) begin
            e.seg = 8'hFF; e.an = 4'hF; e.ft = 1'b0;
            m_pos = 0; m_dig = 16'h0; m_dp = 4'h0; m_br = 3'd0;
        end else begin
            d     = m_pos / SD;
            c     = m_pos % SD;
            nib   = m_dig[d*4 +: 4];
            blank = 1'b0;
`ifdef SEG7_BLANK_EN
            if (d != 0) begin
                blank = 1'b1;
                for (int k = d; k < 4; k++)
                    if (m_dig[k*4 +: 4] != 4'h0) blank = 1'b0;
            end
`endif
            if (c < (int'(m_br) + 1) * (SD / 8)) begin
                e.an  = ~(4'b0001 << d);
                e.seg = {~m_dp[d], blank ? 7'h7F : tbl[nib]};
            end else begin
                e.an  = 4'hF;
                e.seg = 8'hFF;
            end
            e.ft = (m_pos == 4 * SD - 1);
            if (e.ft) begin
                m_dig = digits_in; m_dp = dp_in; m_br = bright;
            end
            m_pos = (m_pos + 1) % (4 * SD);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("seg", 32'(seg), 32'(got.seg));
        chk("an", 32'(an), 32'(got.an));
        chk("frame_tick", 32'(frame_tick), 32'(got.ft));
        if (frame_tick) ft_cnt++;
        if (an != 4'hF) lit_cnt++;
        if (an == 4'hE && seg == 8'h7E) seen_dash = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
        m_pos = 0; m_dig = 16'h0; m_dp = 4'h0; m_br = 3'd0;
        seen_dash = 1'b0;

        // reset with 1234 / full brightness waiting at the inputs
        rst = 1'b1; digits_in = 16'h1234; dp_in = 4'h0; bright = 3'd7;
        run(2);
        chk("reset_seg", 32'(seg), 32'h0000_00FF);
        chk("reset_an", 32'(an), 32'h0000_000F);

        // frame 0: reset data (zeros), brightness 0
        rst = 1'b0; ft_cnt = 0; lit_cnt = 0;
        run(32);
        chk("frame0_ticks", 32'(ft_cnt), 32'd1);
        chk("frame0_lit_cycles", 32'(lit_cnt), 32'd4);

        // frame 1: 1234 at full duty, inputs change mid-frame
        ft_cnt = 0; lit_cnt = 0;
        run(8);
        digits_in = 16'h5678;
        run(24);
        chk("frame1_ticks", 32'(ft_cnt), 32'd1);
        chk("frame1_lit_cycles", 32'(lit_cnt), 32'd32);

        // frame 2: 5678; queue dash-with-dp at dim brightness
        ft_cnt = 0;
        run(4);
        digits_in = 16'h000C; dp_in = 4'b0001; bright = 3'd0;
        run(28);
        chk("frame2_ticks", 32'(ft_cnt), 32'd1);

        // frame 3: dash on digit 0; queue 0050 full brightness
        seen_dash = 1'b0; lit_cnt = 0;
        run(4);
        digits_in = 16'h0050; dp_in = 4'h0; bright = 3'd7;
        run(28);
        chk("dash_dp_seen", 32'(seen_dash), 32'd1);
        chk("frame3_lit_cycles", 32'(lit_cnt), 32'd4);

        // frame 4: 0050, then reset pulsed mid-frame
        run(32);
        run(10);
        rst = 1'b1;
        run(1);
        chk("midreset_seg", 32'(seg), 32'h0000_00FF);
        chk("midreset_an", 32'(an), 32'h0000_000F);
        rst = 1'b0; ft_cnt = 0;
        run(40);
        chk("post_reset_ticks", 32'(ft_cnt), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
